// File: rtl/dmem_byte_loader.sv
// Board-side data-memory writer: assembles a 32-bit word from four switch bytes,
// freezes the CPU through a hold handshake, writes once, then advances the address.
module dmem_byte_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_byte,
    input  logic              btn_addr,
    input  logic [7:0]        sw_data,
    input  logic [ADDR_W-1:0] sw_addr,
    input  logic              hold_ack,
    output logic              hold_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [1:0]        byte_cnt,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WRITE   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic              byte_prev_reg, addr_prev_reg;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] wdata_reg, wdata_next;
    logic [1:0]        cnt_reg, cnt_next;
    logic              byte_edge, addr_edge;

    // Prev copies track the buttons in every state so a press made while busy
    // cannot resurface as an edge once the block returns to IDLE.
    assign byte_edge = btn_byte & ~byte_prev_reg;
    assign addr_edge = btn_addr & ~addr_prev_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            byte_prev_reg <= 1'b0;
            addr_prev_reg <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            cnt_reg       <= 2'd0;
        end else begin
            state_reg     <= state_next;
            byte_prev_reg <= btn_byte;
            addr_prev_reg <= btn_addr;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                // Address load has priority; a simultaneous byte is dropped.
                if (addr_edge) begin
                    addr_next = sw_addr;
                    cnt_next  = 2'd0;
                end else if (byte_edge) begin
                    wdata_next = {wdata_reg[DATA_W-9:0], sw_data};
                    if (cnt_reg == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = REQ;
                    end else begin
                        cnt_next = cnt_reg + 2'd1;
                    end
                end
            end
            REQ: begin
                if (hold_ack) state_next = WRITE;
            end
            WRITE: begin
                state_next = RELEASE;
            end
            RELEASE: begin
                if (!hold_ack) begin
                    addr_next  = addr_reg + ADDR_W'(1);
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hold_req  = (state_reg == REQ) || (state_reg == WRITE);
    assign mem_we    = (state_reg == WRITE);
    assign busy      = (state_reg != IDLE);
    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign byte_cnt  = cnt_reg;

endmodule

// File: tb/tb_dmem_byte_loader.sv
// Directed bench for dmem_byte_loader: byte entry, hold handshake variants,
// address wrap, edge priority, held button and reset mid-write.
module tb_dmem_byte_loader;

    logic        clk;
    logic        rst;
    logic        btn_byte;
    logic        btn_addr;
    logic [7:0]  sw_data;
    logic [5:0]  sw_addr;
    logic        hold_ack;
    logic        hold_req;
    logic        mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  byte_cnt;
    logic        busy;

    int vectors;
    int miscompares;
    int we_count;
    logic [5:0]  we_addr;
    logic [31:0] we_data;

    // 0: manual level, 1: hold_req delayed one cycle, 2: combinational echo
    int   ack_sel;
    logic ack_manual;
    logic ack_dly;

    dmem_byte_loader #(.ADDR_W(6), .DATA_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_byte  (btn_byte),
        .btn_addr  (btn_addr),
        .sw_data   (sw_data),
        .sw_addr   (sw_addr),
        .hold_ack  (hold_ack),
        .hold_req  (hold_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .byte_cnt  (byte_cnt),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign hold_ack = (ack_sel == 1) ? ack_dly :
                      (ack_sel == 2) ? hold_req : ack_manual;

    always @(posedge clk) begin
        if (rst) ack_dly <= 1'b0;
        else     ack_dly <= hold_req;
    end

    always @(posedge clk) begin
        if (mem_we === 1'b1) begin
            we_count <= we_count + 1;
            we_addr  <= mem_addr;
            we_data  <= mem_wdata;
            $display("write: addr=%02h data=%08h", mem_addr, mem_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press_byte(input logic [7:0] b);
        sw_data  = b;
        btn_byte = 1'b1;
        tick();
        btn_byte = 1'b0;
        tick();
    endtask

    task automatic press_addr(input logic [5:0] a);
        sw_addr  = a;
        btn_addr = 1'b1;
        tick();
        btn_addr = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (busy !== 1'b0) begin
            $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
            miscompares++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        vectors++;
        if ({hold_req, mem_we, busy} !== 3'b000) begin
            $display("FAIL reset_ctrl: hold_req/mem_we/busy=%b required 000", {hold_req, mem_we, busy});
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 6'h00 || mem_wdata !== 32'h0 || byte_cnt !== 2'd0) begin
            $display("FAIL reset_data: addr=%h wdata=%h cnt=%0d required 0/0/0", mem_addr, mem_wdata, byte_cnt);
            miscompares++;
        end
        $display("test_reset done");
    endtask

    task automatic test_basic_write();
        int base;
        ack_sel = 1;
        press_addr(6'h05);
        vectors++;
        if (mem_addr !== 6'h05 || byte_cnt !== 2'd0) begin
            $display("FAIL basic_addr: addr=%h cnt=%0d required 05/0", mem_addr, byte_cnt);
            miscompares++;
        end
        press_byte(8'h12);
        press_byte(8'h34);
        press_byte(8'h56);
        vectors++;
        if (byte_cnt !== 2'd3 || mem_wdata !== 32'h00123456) begin
            $display("FAIL basic_3bytes: cnt=%0d wdata=%h required 3/00123456", byte_cnt, mem_wdata);
            miscompares++;
        end
        base = we_count;
        sw_data  = 8'h78;
        btn_byte = 1'b1;
        tick();
        btn_byte = 1'b0;
        vectors++;
        if (busy !== 1'b1 || hold_req !== 1'b1 || byte_cnt !== 2'd0) begin
            $display("FAIL basic_req: busy=%b hold_req=%b cnt=%0d required 1/1/0", busy, hold_req, byte_cnt);
            miscompares++;
        end
        wait_idle(50);
        vectors++;
        if (we_count - base !== 1 || we_addr !== 6'h05 || we_data !== 32'h12345678) begin
            $display("FAIL basic_write: pulses=%0d addr=%h data=%h required 1/05/12345678", we_count - base, we_addr, we_data);
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 6'h06) begin
            $display("FAIL basic_incr: addr=%h required 06", mem_addr);
            miscompares++;
        end
        $display("test_basic_write done");
    endtask

    task automatic test_wrap();
        int base;
        ack_sel = 1;
        press_addr(6'h3F);
        base = we_count;
        press_byte(8'h01);
        press_byte(8'h23);
        press_byte(8'h45);
        press_byte(8'h67);
        wait_idle(50);
        vectors++;
        if (we_count - base !== 1 || we_addr !== 6'h3F || we_data !== 32'h01234567) begin
            $display("FAIL wrap_write: pulses=%0d addr=%h data=%h required 1/3f/01234567", we_count - base, we_addr, we_data);
            miscompares++;
        end
        vectors++;
        if (mem_addr !== 6'h00 || byte_cnt !== 2'd0) begin
            $display("FAIL wrap_addr: addr=%h cnt=%0d required 00/0", mem_addr, byte_cnt);
            miscompares++;
        end
        $display("test_wrap done");
    endtask

    task automatic test_comb_timing();
        ack_sel = 2;
        press_addr(6'h20);
        press_byte(8'h11);
        press_byte(8'h22);
        press_byte(8'h33);
        sw_data  = 8'h44;
        btn_byte = 1'b1;
        tick();
        btn_byte = 1'b0;
        vectors++;
        if (busy !== 1'b1 || mem_we !== 1'b0) begin
            $display("FAIL comb_n1: busy=%b mem_we=%b required 1/0", busy, mem_we);
            miscompares++;
        end
        tick();
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 6'h20 || mem_wdata !== 32'h11223344) begin
            $display("FAIL comb_n2: mem_we=%b addr=%h data=%h required 1/20/11223344", mem_we, mem_addr, mem_wdata);
            miscompares++;
        end
        tick();
        vectors++;
        if (mem_we !== 1'b0 || hold_req !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL comb_n3: mem_we=%b hold_req=%b busy=%b required 0/0/1", mem_we, hold_req, busy);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || mem_addr !== 6'h21) begin
            $display("FAIL comb_n4: busy=%b addr=%h required 0/21", busy, mem_addr);
            miscompares++;
        end
        $display("test_comb_timing done");
    endtask

    task automatic test_ack_stall();
        int base;
        ack_sel    = 0;
        ack_manual = 1'b0;
        press_addr(6'h08);
        base = we_count;
        press_byte(8'hAA);
        press_byte(8'hBB);
        press_byte(8'hCC);
        press_byte(8'hDD);
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                sw_data  = 8'hFF;
                btn_byte = 1'b1;
            end
            if (i == 7) btn_byte = 1'b0;
            tick();
            vectors++;
            if (mem_we !== 1'b0 || busy !== 1'b1) begin
                $display("FAIL stall_cycle%0d: mem_we=%b busy=%b required 0/1", i, mem_we, busy);
                miscompares++;
            end
        end
        vectors++;
        if (mem_wdata !== 32'hAABBCCDD || byte_cnt !== 2'd0 || we_count !== base) begin
            $display("FAIL stall_hold: wdata=%h cnt=%0d pulses=%0d required aabbccdd/0/0", mem_wdata, byte_cnt, we_count - base);
            miscompares++;
        end
        ack_manual = 1'b1;
        tick();
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 6'h08) begin
            $display("FAIL stall_write: mem_we=%b addr=%h required 1/08", mem_we, mem_addr);
            miscompares++;
        end
        ack_manual = 1'b0;
        tick();
        vectors++;
        if (hold_req !== 1'b0 || busy !== 1'b1) begin
            $display("FAIL stall_release: hold_req=%b busy=%b required 0/1", hold_req, busy);
            miscompares++;
        end
        tick();
        vectors++;
        if (busy !== 1'b0 || mem_addr !== 6'h09) begin
            $display("FAIL stall_idle: busy=%b addr=%h required 0/09", busy, mem_addr);
            miscompares++;
        end
        $display("test_ack_stall done");
    endtask

    task automatic test_same_cycle();
        press_byte(8'h01);
        press_byte(8'h02);
        vectors++;
        if (byte_cnt !== 2'd2 || mem_wdata !== 32'hCCDD0102) begin
            $display("FAIL same_pre: cnt=%0d wdata=%h required 2/ccdd0102", byte_cnt, mem_wdata);
            miscompares++;
        end
        sw_addr  = 6'h21;
        sw_data  = 8'h99;
        btn_addr = 1'b1;
        btn_byte = 1'b1;
        tick();
        btn_addr = 1'b0;
        btn_byte = 1'b0;
        vectors++;
        if (mem_addr !== 6'h21 || byte_cnt !== 2'd0 || mem_wdata !== 32'hCCDD0102) begin
            $display("FAIL same_cycle: addr=%h cnt=%0d wdata=%h required 21/0/ccdd0102", mem_addr, byte_cnt, mem_wdata);
            miscompares++;
        end
        tick();
        $display("test_same_cycle done");
    endtask

    task automatic test_held_button();
        sw_data  = 8'h5A;
        btn_byte = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        vectors++;
        if (byte_cnt !== 2'd1 || mem_wdata !== 32'hDD01025A) begin
            $display("FAIL held_button: cnt=%0d wdata=%h required 1/dd01025a", byte_cnt, mem_wdata);
            miscompares++;
        end
        btn_byte = 1'b0;
        tick();
        $display("test_held_button done");
    endtask

    task automatic test_reset_in_write();
        int base;
        ack_sel = 2;
        press_byte(8'h6B);
        press_byte(8'h7C);
        sw_data  = 8'h8D;
        btn_byte = 1'b1;
        tick();
        btn_byte = 1'b0;
        tick();
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 6'h21 || mem_wdata !== 32'h5A6B7C8D) begin
            $display("FAIL rstw_write: mem_we=%b addr=%h data=%h required 1/21/5a6b7c8d", mem_we, mem_addr, mem_wdata);
            miscompares++;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        vectors++;
        if ({hold_req, mem_we, busy} !== 3'b000 || mem_addr !== 6'h00 || mem_wdata !== 32'h0 || byte_cnt !== 2'd0) begin
            $display("FAIL rstw_clear: ctrl=%b addr=%h wdata=%h cnt=%0d required 000/00/0/0",
                     {hold_req, mem_we, busy}, mem_addr, mem_wdata, byte_cnt);
            miscompares++;
        end
        ack_sel = 1;
        base = we_count;
        press_byte(8'hDE);
        press_byte(8'hAD);
        press_byte(8'hBE);
        press_byte(8'hEF);
        wait_idle(50);
        vectors++;
        if (we_count - base !== 1 || we_addr !== 6'h00 || we_data !== 32'hDEADBEEF || mem_addr !== 6'h01) begin
            $display("FAIL rstw_after: pulses=%0d addr=%h data=%h next=%h required 1/00/deadbeef/01",
                     we_count - base, we_addr, we_data, mem_addr);
            miscompares++;
        end
        $display("test_reset_in_write done");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        we_count    = 0;
        we_addr     = '0;
        we_data     = '0;
        ack_sel     = 0;
        ack_manual  = 1'b0;
        rst         = 1'b1;
        btn_byte    = 1'b0;
        btn_addr    = 1'b0;
        sw_data     = 8'h00;
        sw_addr     = 6'h00;
        test_reset();
        test_basic_write();
        test_wrap();
        test_comb_timing();
        test_ack_stall();
        test_same_cycle();
        test_held_button();
        test_reset_in_write();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dmem_byte_loader.md
# dmem_byte_loader

Board-side writer for the pipelined MIPS CPU's data memory: the input-side counterpart to the board-side data-memory display path. The operator enters a 32-bit word one byte at a time from the switches, with a debounced button confirming each byte. After the fourth byte the block freezes the CPU through a hold handshake, performs a single-cycle write into data memory, releases the CPU and auto-increments the target address. It sits in the board top level between the button debouncers and the data memory's write port.

## Interface

Parameters:
- ADDR_W, 6, data memory word-address width
- DATA_W, 32, data word width; fixed at 4 bytes

Ports:
- clk  in  1  system clock (undivided board clock)
- rst  in  1  reset, synchronous, active-high
- btn_byte  in  1  debounced level; a rising edge latches sw_data as the next byte
- btn_addr  in  1  debounced level; a rising edge loads sw_addr and clears the byte count
- sw_data  in  8  byte value from switches
- sw_addr  in  ADDR_W  address value from switches
- hold_ack  in  1  CPU side acknowledges that it is frozen (level)
- hold_req  out  1  request to freeze the CPU clock enable
- mem_we  out  1  data memory write strobe, one clk cycle wide
- mem_addr  out  ADDR_W  current target word address
- mem_wdata  out  DATA_W  assembled word
- byte_cnt  out  2  bytes collected so far in the current word (0-3)
- busy  out  1  high in REQ, WRITE and RELEASE

## Operation

- Edge detect: one registered copy of each button; edge = level & ~prev. The prev registers reset to 0, so a button held through reset produces an edge on the first cycle after reset.
- FSM states: IDLE, REQ, WRITE, RELEASE.
- IDLE:
  - btn_addr edge: mem_addr <= sw_addr, byte_cnt <= 0, mem_wdata unchanged.
  - btn_byte edge: mem_wdata <= {mem_wdata[23:0], sw_data}, so the first byte entered ends up in the MSB.
    - If byte_cnt was 0-2: byte_cnt increments.
    - If byte_cnt was 3: byte_cnt <= 0 and state goes to REQ.
  - Both edges in the same cycle: the address load wins and the byte is dropped.
- REQ: hold_req = 1; stay until hold_ack == 1, then go to WRITE.
- WRITE: mem_we = 1 for exactly this cycle, with mem_addr and mem_wdata stable; hold_req stays 1; next state is RELEASE.
- RELEASE: hold_req = 0; wait for hold_ack == 0, then mem_addr <= mem_addr + 1 (mod 2^ADDR_W, so 63 wraps to 0) and go to IDLE.
- All button edges arriving in REQ, WRITE or RELEASE are discarded, not queued.
- hold_ack high while in IDLE is ignored.
- rst in any state, including mid-handshake: next edge forces IDLE, and every output and register is cleared.

## Timing

- Reset values:
  - hold_req = 0, mem_we = 0, busy = 0
  - mem_addr = 0, mem_wdata = 0, byte_cnt = 0
  - FSM = IDLE, prev registers = 0
- Outputs are registered, except mem_we, busy and hold_req, which decode directly from the state register. All outputs change only on posedge clk.
- Button edge sampled at cycle N → byte_cnt/mem_wdata/mem_addr update visible in cycle N+1.
- 4th byte edge at cycle N → hold_req = 1 and busy = 1 from cycle N+1.
- hold_ack first sampled high at cycle M (in REQ) → mem_we = 1 in cycle M+1 only.
- hold_req falls in cycle M+2.
- hold_ack sampled low at cycle K (in RELEASE) → mem_addr + 1, busy = 0 and IDLE in cycle K+1.
- With hold_ack responding combinationally: 4th byte → mem_we in 2 cycles; → busy low in 4 cycles.
- No timeout: REQ and RELEASE wait indefinitely.

## Test plan

- Reset, then btn_addr with sw_addr = 6'h05, then bytes 8'h12, 8'h34, 8'h56, 8'h78, with hold_ack tied to hold_req delayed one cycle → exactly one mem_we pulse with mem_addr = 5 and mem_wdata = 32'h12345678; mem_addr = 6 afterwards.
- btn_addr with sw_addr = 6'h3F, enter 4 bytes → write to 63, then mem_addr wraps to 0 and byte_cnt = 0.
- hold_ack held low for 20 cycles after hold_req rises → mem_we stays 0 and busy stays 1 throughout; a btn_byte edge during the wait does not change mem_wdata or byte_cnt.
- btn_addr and btn_byte rising in the same cycle with byte_cnt = 2 → mem_addr = sw_addr, byte_cnt = 0, mem_wdata unchanged.
- rst asserted for one cycle while in WRITE → next cycle hold_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0; a subsequent full 4-byte entry writes normally.
- btn_byte held high for 50 cycles → only one byte is latched (byte_cnt increments by exactly 1).
